// File: rtl/reception.sv
// UART receiver: 2-flop synchronised line, start-bit centring, SIZE data bits LSB first, stop-bit check.
// data_out holds the last good word; rx_valid / frame_err are single-cycle registered pulses.
module reception #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [SIZE-1:0] data_out,
  output logic            rx_valid,
  output logic            rx_busy,
  output logic            frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            rx_s;
  logic            armed;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;
  logic [SIZE-1:0] shift_reg;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync      <= 2'b11;
      armed     <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // A falling edge only counts once the line has been seen idle,
          // so a stuck-low line or a low stop bit never restarts a frame.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed   <= 1'b0;
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) state   <= STOP;
            else                     bit_idx <= bit_idx + BW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leave at mid stop bit: half a bit of slack for a back-to-back start.
          if (cnt == FULL) begin
            cnt     <= '0;
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (rx_s) begin
              data_out <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  pulse_excl: assert property (@(posedge clk) disable iff (rst) !(rx_valid && frame_err));

endmodule

// File: tb/tb_reception.sv
// Scoreboard bench for reception: frames are driven bit-serially and expected pulses queued with their cycle.
module tb_reception;
  localparam int SIZE = 8;
  localparam int CPB  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic [SIZE-1:0] data_out;
  logic            rx_valid;
  logic            rx_busy;
  logic            frame_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [SIZE-1:0] last_good;

  typedef struct {
    bit              err;
    logic [SIZE-1:0] data;
    int              at;
  } exp_t;
  exp_t sb[$];

  reception #(.SIZE(SIZE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_out(data_out), .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: every rx_valid / frame_err must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_valid || frame_err)) begin
      chk("excl", {31'b0, rx_valid & frame_err}, 32'd0);
      chk("busy_at_pulse", {31'b0, rx_busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("spurious", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("kind", {31'b0, frame_err}, {31'b0, e.err});
        chk("data", {24'b0, data_out}, {24'b0, e.data});
        chk("time", cyc, e.at);
      end
    end
  end

  // Called at a negedge; drives one full frame (start, data LSB first, stop).
  task automatic send(input logic [SIZE-1:0] d, input logic stop_b);
    exp_t e;
    e.err  = !stop_b;
    e.data = stop_b ? d : last_good;
    // 2 sync flops + decision edge, then half a bit plus SIZE+1 bits to the stop sample.
    e.at   = cyc + 3 + CPB/2 + (SIZE+1)*CPB;
    sb.push_back(e);
    if (stop_b) last_good = d;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    chk("busy_mid", {31'b0, rx_busy}, 32'd1);
    for (int i = 0; i < SIZE; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4*CPB*(SIZE+2) && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 32'd0);
  endtask

  task automatic check_quiet(input string tag, input logic [SIZE-1:0] d);
    chk({tag, "_data"}, {24'b0, data_out}, {24'b0, d});
    chk({tag, "_busy"}, {31'b0, rx_busy}, 32'd0);
    chk({tag, "_valid"}, {31'b0, rx_valid}, 32'd0);
    chk({tag, "_err"}, {31'b0, frame_err}, 32'd0);
  endtask

  initial begin
    logic [SIZE-1:0] w;
    rst = 1'b1;
    rx  = 1'b1;
    last_good = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset", 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame with exact pulse timing.
    send(8'hA5, 1'b1);
    drain("drain_a5");
    repeat (CPB) @(negedge clk);

    // Back-to-back frames, no idle gap.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drain("drain_b2b");
    repeat (CPB) @(negedge clk);

    // Short low glitch is rejected at mid start bit.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3*CPB) @(negedge clk);
    check_quiet("glitch", 8'hFF);

    // Framing error keeps old data, then a clean retry.
    send(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    send(8'h3C, 1'b1);
    drain("drain_3c");
    repeat (CPB) @(negedge clk);

    // Reset in the middle of data bit 4 of 0x5A: frame abandoned.
    w  = 8'h5A;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = w[i];
      repeat (CPB) @(negedge clk);
    end
    rx = w[4];
    repeat (CPB/2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrst", 8'h00);
    rst = 1'b0;
    rx  = 1'b1;
    last_good = '0;
    repeat (2*CPB) @(negedge clk);
    check_quiet("postrst", 8'h00);
    send(8'h96, 1'b1);
    drain("drain_96");
    repeat (CPB) @(negedge clk);

    // Continuous stream of all 256 words, in order.
    for (int i = 0; i < 256; i++) send(i[7:0], 1'b1);
    drain("drain_stream");
    check_quiet("final", 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
